// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit for the MIPS EX stage.
// Multiply uses a 2*WIDTH-bit shift-add; divide uses restoring
// shift-subtract. Operands are reduced to magnitudes on acceptance and
// the result is sign-corrected in a single FIX cycle before HI/LO are
// written. A zero divisor bypasses the iteration entirely.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Two's complement negate of a WIDTH-bit value.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Two's complement negate of a 2*WIDTH-bit value.
  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of an operand; unsigned operands pass through unchanged.
  function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] v,
                                             input logic             is_signed);
    return (is_signed && v[WIDTH-1]) ? neg_w(v) : v;
  endfunction

  state_t               state_r;
  state_t               state_nxt_s;

  logic                 is_div_r;
  logic                 neg_a_r;
  logic                 neg_b_r;
  logic                 dz_pend_r;
  logic [WIDTH-1:0]     opb_r;
  logic [2*WIDTH-1:0]   prod_r;
  logic [CNT_W-1:0]     cnt_r;

  logic                 busy_r;
  logic                 done_r;
  logic                 dz_r;
  logic [WIDTH-1:0]     hi_r;
  logic [WIDTH-1:0]     lo_r;

  logic                 accept_s;
  logic                 b_zero_s;
  logic                 last_iter_s;
  logic                 complete_s;

  logic [WIDTH:0]       mul_sum_s;
  logic [WIDTH:0]       mul_add_s;
  logic [2*WIDTH-1:0]   mul_next_s;
  logic [WIDTH:0]       div_shift_s;
  logic [WIDTH:0]       div_diff_s;
  logic [2*WIDTH-1:0]   div_next_s;

  logic [2*WIDTH-1:0]   prod_neg_s;
  logic [WIDTH-1:0]     res_hi_s;
  logic [WIDTH-1:0]     res_lo_s;

  assign accept_s    = (state_r == ST_IDLE) && start && !flush;
  assign b_zero_s    = op[1] && (b == {WIDTH{1'b0}});
  assign last_iter_s = (cnt_r == CNT_W'(1));
  assign complete_s  = (state_r == ST_FIX) && !flush;

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; flush aborts any in-flight operation.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = b_zero_s ? ST_FIX : ST_CALC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_nxt_s = ST_IDLE;
        end else if (last_iter_s) begin
          state_nxt_s = ST_FIX;
        end else begin
          state_nxt_s = ST_CALC;
        end
      end
      ST_FIX: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // One radix-2 iteration: shift-add for multiply, restoring step for divide.
  always_comb begin
    mul_sum_s   = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, opb_r};
    mul_add_s   = prod_r[0] ? mul_sum_s : {1'b0, prod_r[2*WIDTH-1:WIDTH]};
    mul_next_s  = {mul_add_s, prod_r[WIDTH-1:1]};
    div_shift_s = prod_r[2*WIDTH-1:WIDTH-1];
    div_diff_s  = div_shift_s - {1'b0, opb_r};
    // A clear top bit means no borrow: the divisor fits, quotient bit is 1.
    if (!div_diff_s[WIDTH]) begin
      div_next_s = {div_diff_s[WIDTH-1:0], prod_r[WIDTH-2:0], 1'b1};
    end else begin
      div_next_s = {div_shift_s[WIDTH-1:0], prod_r[WIDTH-2:0], 1'b0};
    end
  end

  // Sign correction applied in FIX; the zero-divisor image is already final.
  always_comb begin
    prod_neg_s = neg_2w(prod_r);
    res_hi_s   = prod_r[2*WIDTH-1:WIDTH];
    res_lo_s   = prod_r[WIDTH-1:0];
    if (dz_pend_r) begin
      res_hi_s = prod_r[2*WIDTH-1:WIDTH];
      res_lo_s = prod_r[WIDTH-1:0];
    end else if (!is_div_r) begin
      if (neg_a_r ^ neg_b_r) begin
        res_hi_s = prod_neg_s[2*WIDTH-1:WIDTH];
        res_lo_s = prod_neg_s[WIDTH-1:0];
      end else begin
        res_hi_s = prod_r[2*WIDTH-1:WIDTH];
        res_lo_s = prod_r[WIDTH-1:0];
      end
    end else begin
      // Quotient follows the sign product; remainder follows the dividend.
      res_lo_s = (neg_a_r ^ neg_b_r) ? neg_w(prod_r[WIDTH-1:0]) : prod_r[WIDTH-1:0];
      res_hi_s = neg_a_r ? neg_w(prod_r[2*WIDTH-1:WIDTH]) : prod_r[2*WIDTH-1:WIDTH];
    end
  end

  // Operand capture on acceptance and iteration of the working registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      is_div_r  <= 1'b0;
      neg_a_r   <= 1'b0;
      neg_b_r   <= 1'b0;
      dz_pend_r <= 1'b0;
      opb_r     <= {WIDTH{1'b0}};
      prod_r    <= {(2*WIDTH){1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            is_div_r <= op[1];
            neg_a_r  <= op[0] & a[WIDTH-1];
            neg_b_r  <= op[0] & b[WIDTH-1];
            opb_r    <= mag_w(b, op[0]);
            if (b_zero_s) begin
              dz_pend_r <= 1'b1;
              prod_r    <= {a, {WIDTH{1'b1}}};
              cnt_r     <= {CNT_W{1'b0}};
            end else begin
              dz_pend_r <= 1'b0;
              prod_r    <= {{WIDTH{1'b0}}, mag_w(a, op[0])};
              cnt_r     <= CNT_W'(WIDTH);
            end
          end
        end
        ST_CALC: begin
          if (!flush) begin
            prod_r <= is_div_r ? div_next_s : mul_next_s;
            cnt_r  <= cnt_r - CNT_W'(1);
          end
        end
        ST_FIX: begin
          cnt_r <= {CNT_W{1'b0}};
        end
        default: begin
          cnt_r <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Registered handshake outputs and architectural HI/LO/flag update.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
      hi_r   <= {WIDTH{1'b0}};
      lo_r   <= {WIDTH{1'b0}};
    end else begin
      busy_r <= (state_nxt_s != ST_IDLE);
      done_r <= complete_s;
      if (complete_s) begin
        hi_r <= res_hi_s;
        lo_r <= res_lo_s;
        dz_r <= dz_pend_r;
      end
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dz_r;
  assign hi          = hi_r;
  assign lo          = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with a result scoreboard.
module tb_mult_div_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'd0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          flush = 1'b0;
  logic          busy;
  logic          done;
  logic          div_by_zero;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int checks = 0;
  int failures = 0;

  logic [2*W:0]  sb_q[$];
  logic [W-1:0]  last_hi = '0;
  logic [W-1:0]  last_lo = '0;
  logic          last_dz = 1'b0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {div_by_zero, hi, lo}
  function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] x,
                                        input logic [W-1:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: begin p = {32'd0, x} * {32'd0, y}; return {1'b0, p}; end
      2'd1: begin p = sx * sy; return {1'b0, p}; end
      2'd2: begin
        if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
        return {1'b0, x % y, x / y};
      end
      default: begin
        if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Launch one op, track busy, wait for done and score the result.
  // With inj set, a second start is pulsed mid-operation and must be ignored.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input bit inj);
    logic [2*W:0] e;
    int exp_lat, lat, busy_cnt;
    bit got;
    exp_lat = (o[1] && y == 0) ? 1 : W + 1;
    sb_q.push_back(model(o, x, y));
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    got = 0;
    lat = 0;
    for (int i = 1; i <= 100 && !got; i++) begin
      if (inj && i == 5) begin
        start = 1'b1; op = 2'd0; a = 32'h1234_5678; b = 32'h0000_0009;
      end
      if (inj && i == 6) start = 1'b0;
      tick();
      if (busy) busy_cnt++;
      if (done) begin
        got = 1;
        lat = i;
      end
    end
    start = 1'b0;
    check({tag, " done_seen"}, 64'(got), 64'd1);
    e = sb_q.pop_front();
    last_dz = e[2*W];
    last_hi = e[2*W-1:W];
    last_lo = e[W-1:0];
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
    check({tag, " hi"}, 64'(hi), 64'(last_hi));
    check({tag, " lo"}, 64'(lo), 64'(last_lo));
    check({tag, " div_by_zero"}, 64'(div_by_zero), 64'(last_dz));
  endtask

  initial begin
    int dcnt;
    // Reset state
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset dz", 64'(div_by_zero), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);
    tick();
    tick();
    rst_b = 1'b1;
    tick();

    // 1: full-scale unsigned multiply
    run_op("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("multu_max hi_const", 64'(hi), 64'hFFFF_FFFE);
    check("multu_max lo_const", 64'(lo), 64'h0000_0001);
    tick();
    check("done one-cycle pulse", 64'(done), 64'd0);

    // 2: signed multiply, then back-to-back start in the done cycle
    run_op("mult_neg", 2'd1, 32'hFFFF_FFFD, 32'd7, 0);
    run_op("multu_b2b", 2'd0, 32'd6, 32'd7, 0);
    check("multu_b2b lo_const", 64'(lo), 64'd42);
    run_op("mult_negneg", 2'd1, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 0);

    // 3: signed/unsigned divide, remainder sign
    run_op("div_neg", 2'd3, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("divu_7_2", 2'd2, 32'd7, 32'd2, 0);
    run_op("div_negdivisor", 2'd3, 32'd7, 32'hFFFF_FFFE, 0);
    run_op("divu_big", 2'd2, 32'hDEAD_BEEF, 32'h0000_1234, 0);

    // 4: MIN / -1 wraps
    run_op("div_min_m1", 2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_min_m1 lo_const", 64'(lo), 64'h8000_0000);

    // 5: divide by zero, flag persistence
    run_op("divu_zero", 2'd2, 32'd5, 32'd0, 0);
    run_op("div_zero_signed", 2'd3, 32'hFFFF_FFFB, 32'd0, 0);
    for (int i = 0; i < 4; i++) tick();
    check("dz persists idle", 64'(div_by_zero), 64'd1);

    // 6a: flush MULT 3x3 at cycle 10; dz and hi/lo must survive
    op = 2'd1; a = 32'd3; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    check("flush pre busy", 64'(busy), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush busy drop", 64'(busy), 64'd0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dcnt++;
      tick();
    end
    check("flush no done", 64'(dcnt), 64'd0);
    check("flush hi kept", 64'(hi), 64'(last_hi));
    check("flush lo kept", 64'(lo), 64'(last_lo));
    check("flush dz kept", 64'(div_by_zero), 64'd1);

    // flush and start together in IDLE: flush wins
    op = 2'd0; a = 32'd2; b = 32'd2; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("flush+start busy", 64'(busy), 64'd0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) dcnt++;
    end
    check("flush+start no done", 64'(dcnt), 64'd0);

    // Flag clears on next non-zero completion
    run_op("divu_8_4", 2'd2, 32'd8, 32'd4, 0);
    check("dz cleared", 64'(div_by_zero), 64'd0);

    // start while busy is ignored
    run_op("mult_ignore_start", 2'd1, 32'h0001_0003, 32'hFFFF_FF00, 1);

    // 6b: reset mid-DIV
    op = 2'd3; a = 32'd1000; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 20; i++) tick();
    rst_b = 1'b0;
    #1;
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset done", 64'(done), 64'd0);
    check("midreset dz", 64'(div_by_zero), 64'd0);
    check("midreset hi", 64'(hi), 64'd0);
    check("midreset lo", 64'(lo), 64'd0);
    tick();
    rst_b = 1'b1;
    tick();
    run_op("post_reset_div", 2'd3, 32'hFFFF_FC18, 32'd7, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
